// File: rtl/memaccess.sv
// memaccess: Bexkat1 memory stage; execute inputs in, Wishbone master for loads/stores, stall_o upstream, registered writeback outputs
module memaccess #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] result_i,
  input  logic [31:0] reg_data1_i,
  input  logic [1:0]  reg_write_i,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic [31:0] result_o,
  output logic [1:0]  reg_write_o,
  output logic        stall_o,
  output logic        bus_err_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  input  logic        bus_err_i
);
  localparam logic [3:0] T_LOAD = 4'ha;
  localparam logic [3:0] T_STORE = 4'hb;
  typedef enum logic {IDLE, BUS} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic done, mem_op, is_store;
  logic [1:0] w;
  logic [3:0] sel_n;
  logic [31:0] dat_n, ld;
  assign is_store = ir_i[31:28] == T_STORE;
  assign mem_op = is_store || ir_i[31:28] == T_LOAD;
  assign w = ir_i[25:24];
  assign sel_n = w == 2'd1 ? (result_i[1] ? 4'h3 : 4'hc) : w == 2'd2 ? 4'h8 >> result_i[1:0] : 4'hf;
  assign dat_n = w == 2'd1 ? {2{reg_data1_i[15:0]}} : w == 2'd2 ? {4{reg_data1_i[7:0]}} : reg_data1_i;
  assign ld = bus_sel_o == 4'hc ? {16'h0, bus_dat_i[31:16]} :
              bus_sel_o == 4'h3 ? {16'h0, bus_dat_i[15:0]} :
              bus_sel_o == 4'h8 ? {24'h0, bus_dat_i[31:24]} :
              bus_sel_o == 4'h4 ? {24'h0, bus_dat_i[23:16]} :
              bus_sel_o == 4'h2 ? {24'h0, bus_dat_i[15:8]} :
              bus_sel_o == 4'h1 ? {24'h0, bus_dat_i[7:0]} : bus_dat_i;
  assign bus_stb_o = bus_cyc_o;
  always_comb begin
    done = state == BUS && (bus_ack_i || bus_err_i || cnt == 8'(TIMEOUT));
    stall_o = state == IDLE ? mem_op : !done;
    state_n = state == IDLE ? (mem_op ? BUS : IDLE) : (done ? IDLE : BUS);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      ir_o <= '0;
      pc_o <= '0;
      result_o <= '0;
      reg_write_o <= '0;
      bus_err_o <= 1'b0;
      bus_cyc_o <= 1'b0;
      bus_we_o <= 1'b0;
      bus_adr_o <= '0;
      bus_sel_o <= '0;
      bus_dat_o <= '0;
    end else begin
      state <= state_n;
      bus_err_o <= 1'b0;
      if (stall_o) begin
        ir_o <= '0;
        reg_write_o <= '0;
        result_o <= '0;
      end
      if (state == IDLE) begin
        if (mem_op) begin
          bus_cyc_o <= 1'b1;
          bus_we_o <= is_store;
          bus_adr_o <= {result_i[31:2], 2'b00};
          bus_sel_o <= sel_n;
          bus_dat_o <= dat_n;
          cnt <= '0;
        end else begin
          ir_o <= ir_i;
          pc_o <= pc_i;
          result_o <= result_i;
          reg_write_o <= reg_write_i;
        end
      end else begin
        cnt <= cnt == 8'hff ? cnt : cnt + 8'd1;
        if (done) begin
          bus_cyc_o <= 1'b0;
          ir_o <= ir_i;
          pc_o <= pc_i;
          // ack has priority over err; err and timeout squash the register write
          result_o <= bus_ack_i ? (bus_we_o ? result_i : ld) : '0;
          reg_write_o <= bus_ack_i ? reg_write_i : 2'b00;
          bus_err_o <= !bus_ack_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_memaccess.sv
module tb_memaccess;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  logic [63:0] ir_i = 0, ir_o;
  logic [31:0] pc_i = 0, result_i = 0, reg_data1_i = 0, pc_o, result_o;
  logic [1:0] reg_write_i = 0, reg_write_o;
  logic stall_o, bus_err_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_ack_i = 0, bus_err_i = 0;
  logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i = 0;
  logic [3:0] bus_sel_o;
  int checks = 0, failures = 0;
  typedef struct {logic [63:0] ir; logic [31:0] pc; logic [31:0] res; logic [1:0] rw; logic err;} exp_t;
  exp_t q[$];

  memaccess #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .ir_i(ir_i), .pc_i(pc_i), .result_i(result_i),
    .reg_data1_i(reg_data1_i), .reg_write_i(reg_write_i), .ir_o(ir_o), .pc_o(pc_o),
    .result_o(result_o), .reg_write_o(reg_write_o), .stall_o(stall_o), .bus_err_o(bus_err_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
    .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [3:0] t, input logic [1:0] w, input logic [7:0] tag);
    return {32'h0, t, 2'b00, w, 16'h0, tag};
  endfunction

  // monitor: every non-zero ir_o is a retired instruction; zero ir_o is a bubble/NOP
  always @(negedge clk) begin
    if (!rst) begin
      if (ir_o != 0) begin
        if (q.size() == 0) chk("unexpected_output", ir_o, 64'h0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("ir_o", ir_o, e.ir);
          chk("pc_o", {32'h0, pc_o}, {32'h0, e.pc});
          if (!e.err) chk("result_o", {32'h0, result_o}, {32'h0, e.res});
          chk("reg_write_o", {62'h0, reg_write_o}, {62'h0, e.rw});
          chk("bus_err_o", {63'h0, bus_err_o}, {63'h0, e.err});
        end
      end else begin
        chk("bubble_rw_err", {61'h0, bus_err_o, reg_write_o}, 64'h0);
      end
    end
  end

  task automatic idle_inputs();
    ir_i = 0; pc_i = 0; result_i = 0; reg_data1_i = 0; reg_write_i = 0;
    bus_ack_i = 0; bus_err_i = 0; bus_dat_i = 0;
  endtask

  // term: bus cycle index of ack/err (0 = none, wait for timeout)
  task automatic run_mem(input string nm, input logic [63:0] ir, input logic [31:0] pc,
                         input logic [31:0] addr, input logic [31:0] d1, input logic [1:0] rw,
                         input int term, input bit ack, input bit err, input logic [31:0] rdat,
                         input logic [3:0] esel, input logic [31:0] edat, input logic ewe,
                         input logic [31:0] eres, input bit eerr);
    int k;
    int t;
    t = term == 0 ? TO + 1 : term;
    @(posedge clk); #1;
    ir_i = ir; pc_i = pc; result_i = addr; reg_data1_i = d1; reg_write_i = rw;
    q.push_back('{ir, pc, eres, eerr ? 2'b00 : rw, eerr});
    @(negedge clk);
    chk({nm, "_stall0"}, {63'h0, stall_o}, 64'h1);
    chk({nm, "_cyc0"}, {63'h0, bus_cyc_o}, 64'h0);
    k = 0;
    do begin
      k++;
      @(posedge clk); #1;
      bus_ack_i = ack && k == term;
      bus_err_i = err && k == term;
      bus_dat_i = rdat;
      @(negedge clk);
      chk({nm, "_cyc"}, {62'h0, bus_cyc_o, bus_stb_o}, 64'h3);
      chk({nm, "_bubble"}, ir_o, 64'h0);
      if (k == 1) begin
        chk({nm, "_adr"}, {32'h0, bus_adr_o}, {32'h0, addr[31:2], 2'b00});
        chk({nm, "_sel"}, {60'h0, bus_sel_o}, {60'h0, esel});
        chk({nm, "_we"}, {63'h0, bus_we_o}, {63'h0, ewe});
        if (ewe) chk({nm, "_dat"}, {32'h0, bus_dat_o}, {32'h0, edat});
      end
    end while (stall_o && k < TO + 3);
    chk({nm, "_stall_cycles"}, 64'(k), 64'(t));
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk({nm, "_cyc_drop"}, {63'h0, bus_cyc_o}, 64'h0);
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {ir_o[31:0], pc_o ^ result_o}, 64'h0);
    chk("reset_bus", {57'h0, bus_cyc_o, bus_stb_o, bus_we_o, stall_o, bus_err_o, reg_write_o}, 64'h0);
    @(posedge clk); #1;
    rst = 0;
    // ALU pass-through
    @(posedge clk); #1;
    ir_i = mk(4'h9, 2'd0, 8'h01); pc_i = 32'h100; result_i = 32'h1234; reg_write_i = 2'd1;
    q.push_back('{mk(4'h9, 2'd0, 8'h01), 32'h100, 32'h1234, 2'd1, 1'b0});
    @(negedge clk);
    chk("alu_stall", {62'h0, stall_o, bus_cyc_o}, 64'h0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("alu_stall1", {62'h0, stall_o, bus_cyc_o}, 64'h0);
    run_mem("ldw", mk(4'ha, 2'd0, 8'h02), 32'h104, 32'h1000, 0, 2'd1, 1, 1, 0, 32'hdeadbeef, 4'hf, 0, 0, 32'hdeadbeef, 0);
    run_mem("stb", mk(4'hb, 2'd2, 8'h03), 32'h108, 32'h1003, 32'hab, 2'd0, 4, 1, 0, 0, 4'h1, 32'habababab, 1, 32'h1003, 0);
    run_mem("ldh3", mk(4'ha, 2'd1, 8'h04), 32'h10c, 32'h2002, 0, 2'd1, 1, 1, 0, 32'h1111beef, 4'h3, 0, 0, 32'h0000beef, 0);
    run_mem("ldhc", mk(4'ha, 2'd1, 8'h05), 32'h110, 32'h2001, 0, 2'd1, 2, 1, 0, 32'h1111beef, 4'hc, 0, 0, 32'h00001111, 0);
    run_mem("ldb1", mk(4'ha, 2'd2, 8'h06), 32'h114, 32'h3001, 0, 2'd2, 1, 1, 0, 32'h11ab2233, 4'h4, 0, 0, 32'h000000ab, 0);
    run_mem("sth", mk(4'hb, 2'd1, 8'h07), 32'h118, 32'h3002, 32'h5566cafe, 2'd0, 1, 1, 0, 0, 4'h3, 32'hcafecafe, 1, 32'h3002, 0);
    run_mem("stw3", mk(4'hb, 2'd3, 8'h08), 32'h11c, 32'h4000, 32'h01234567, 2'd0, 1, 1, 0, 0, 4'hf, 32'h01234567, 1, 32'h4000, 0);
    run_mem("tmo", mk(4'ha, 2'd0, 8'h09), 32'h120, 32'h5000, 0, 2'd1, 0, 0, 0, 0, 4'hf, 0, 0, 0, 1);
    run_mem("err", mk(4'ha, 2'd0, 8'h0a), 32'h124, 32'h5004, 0, 2'd1, 2, 0, 1, 0, 4'hf, 0, 0, 0, 1);
    run_mem("ackerr", mk(4'ha, 2'd0, 8'h0b), 32'h128, 32'h5008, 0, 2'd1, 2, 1, 1, 32'h0badf00d, 4'hf, 0, 0, 32'h0badf00d, 0);
    // reset in the middle of a bus cycle
    @(posedge clk); #1;
    ir_i = mk(4'ha, 2'd0, 8'h0c); pc_i = 32'h12c; result_i = 32'h6000; reg_write_i = 2'd1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_precyc", {63'h0, bus_cyc_o}, 64'h1);
    @(posedge clk); #1;
    rst = 1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_mid_bus", {59'h0, bus_cyc_o, bus_stb_o, stall_o, bus_err_o, bus_we_o}, 64'h0);
    chk("rst_mid_outs", {ir_o[31:0], pc_o | result_o}, 64'h0);
    run_mem("ldpost", mk(4'ha, 2'd0, 8'h0d), 32'h130, 32'h7000, 0, 2'd3, 1, 1, 0, 32'h13579bdf, 4'hf, 0, 0, 32'h13579bdf, 0);
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memaccess.md
# memaccess

Bexkat1 pipeline memory stage, directly downstream of execute. Consumes the execute outputs (instruction word, PC, ALU result, register data and write enables) and runs one bus cycle per load or store over a classic Wishbone master port. Stalls the upstream pipeline while a cycle is outstanding. Passes load data, or the unchanged ALU result, forward to writeback with a one-cycle registered latency.

## Interface
- TIMEOUT, default 255: number of cycles without ack/err after which a bus cycle is aborted; 8-bit counter.
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high (already decided)
- ir_i  in  64  instruction from execute; held stable by upstream while stall_o=1
- pc_i  in  32  PC from execute
- result_i  in  32  ALU result; byte address for T_LOAD/T_STORE
- reg_data1_i  in  32  store data (rA value)
- reg_write_i  in  2  register write enables from execute
- ir_o  out  64  instruction to writeback
- pc_o  out  32  PC to writeback
- result_o  out  32  load data or passed-through result_i
- reg_write_o  out  2  write enables to writeback
- stall_o  out  1  hold upstream stages (combinational)
- bus_err_o  out  1  one-cycle pulse on bus error or timeout
- bus_cyc_o, bus_stb_o  out  1  Wishbone cycle/strobe
- bus_we_o  out  1  1=store
- bus_adr_o  out  32  word address {result_i[31:2],2'b00}
- bus_sel_o  out  4  byte lanes, big-endian
- bus_dat_o  out  32  store data, lane-replicated
- bus_dat_i  in  32  read data
- bus_ack_i, bus_err_i  in  1  termination

## Operation
- Memory op: ir_i[31:28] is T_LOAD or T_STORE. Width comes from ir_i[25:24]: 0 word, 1 halfword, 2 byte, 3 treated as word.
- Lanes are big-endian. Word: sel 4'hf. Half: addr[1]=0 gives 4'hc, addr[1]=1 gives 4'h3. Byte: addr[1:0]=0,1,2,3 gives 8,4,2,1. Unused low address bits are ignored, with no misalignment fault.
- Store data: word as-is; half as {d[15:0],d[15:0]}; byte as {4{d[7:0]}}.
- Load data: the selected lanes are right-justified and zero-extended into result_o.
- FSM states:
  - IDLE: a memory op on ir_i gives stall_o=1. At the clock edge, latch addr/sel/we/data, set cyc=stb=1, clear the timeout counter, and go to BUS. Any other op: register the inputs to the outputs, stall_o=0.
  - BUS: cyc=stb=1 and the counter increments. On ack_i: stall_o=0; at the edge, drop cyc/stb, register outputs (result_o = load data for loads, result_i for stores), go to IDLE.
  - On err_i, or counter==TIMEOUT: stall_o=0; at the edge, drop cyc/stb, pulse bus_err_o, emit ir_o/pc_o with reg_write_o=0, go to IDLE.
- While stall_o=1, a bubble is registered each cycle: ir_o=0, reg_write_o=0, result_o=0, pc_o holds.
- ack_i and err_i in the same cycle: ack wins, no error pulse.
- ack_i/err_i seen in IDLE are ignored.

## Timing
- Reset (synchronous): all outputs 0, FSM goes to IDLE, counter 0. Reset during BUS drops cyc/stb at that edge; the cycle is abandoned with no error pulse.
- Non-memory op: 1-cycle latency, no stall.
- Memory op presented in cycle 0: stall_o=1 in cycle 0, bus signals active from cycle 1. If ack arrives in cycle k≥1, stall_o falls in cycle k and outputs are valid in cycle k+1. Minimum occupancy is 2 cycles.
- Back-to-back memory ops: the second is seen in IDLE one cycle after the first completes, so cyc drops for at least one cycle between them.
- Timeout fires in the cycle where the counter equals TIMEOUT, TIMEOUT+1 cycles after bus start. The counter saturates and never wraps.

## Test plan
- ALU op (result_i=0x1234, reg_write_i=1) -> next cycle result_o=0x1234, reg_write_o=1, stall_o never 1, cyc never 1.
- Word load at 0x1000, ack in first bus cycle with dat_i=0xDEADBEEF -> adr=0x1000, sel=f, we=0; stall_o high for exactly 1 cycle; result_o=0xDEADBEEF two cycles after issue.
- Byte store at 0x1003 with data 0x000000AB, ack after 3 wait cycles -> sel=1, dat_o=0xABABABAB, we=1; stall_o high 4 cycles; one bubble per stalled cycle.
- Halfword load at 0x2002, dat_i=0x1111BEEF -> sel=3, result_o=0x0000BEEF.
- No ack, TIMEOUT=4 -> cyc high 5 cycles, bus_err_o pulses once, reg_write_o=0, FSM returns to IDLE. Repeat with err_i asserted in cycle 2: same response, and ack+err together gives normal completion.
- rst_i asserted mid-BUS -> cyc/stb/stall_o/all outputs 0 after that edge; a subsequent load completes normally.
